mult_sequencer: RTL and testbench

- Multi-cycle unsigned multiply engine with its own sequencer, for the EX stage of the pipeline.
- The EX stage hands it an OP_MULT instruction. It runs a radix-2 shift-add over DATA_WIDTH cycles and holds the pipeline with a stall output while it works.
- It then offers the low result word to writeback through a valid/ready handshake. The high word is latched into a HI register.
- This turns OP_MULT from a decode-only opcode (WB_EN=0) into a working instruction that writes back.

---
 rtl/mult_sequencer_pkg.sv | 18 +
 rtl/mult_datapath.sv | 44 ++++
 rtl/mult_sequencer.sv | 118 +++++++++++
 tb/tb_mult_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_sequencer_pkg.sv
// Shared encodings and defaults for the multi-cycle multiply engine in the EX stage.
// Imported by the sequencer and its shift-add datapath.
package mult_sequencer_pkg;

  localparam int DATA_WIDTH_DEF   = 16;
  localparam int REG_ADDR_LEN_DEF = 4;
  localparam int CNT_WIDTH_DEF    = 5;

  // EX command encoding that routes an instruction into this engine
  localparam logic [3:0] EXE_MULT = 4'hD;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_RUN  = 2'd1,
    MS_DONE = 2'd2
  } ms_state_e;

endpackage

// File: rtl/mult_datapath.sv
// Radix-2 shift-add multiplier core: the multiplier sits in the low half of the
// accumulator and shifts out through bit 0 as the partial product shifts in.
module mult_datapath
  import mult_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic                      step,
  input  logic                      flush,
  input  logic [DATA_WIDTH-1:0]     op_a,
  input  logic [DATA_WIDTH-1:0]     op_b,
  output logic [2*DATA_WIDTH-1:0]   prod_next
);

  logic [2*DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0]   mcand;
  logic [DATA_WIDTH-1:0]   addend;
  logic [DATA_WIDTH:0]     sum;

  // Carry out of the upper-half add becomes the new MSB after the shift
  always_comb begin
    addend    = acc[0] ? mcand : '0;
    sum       = {1'b0, acc[2*DATA_WIDTH-1:DATA_WIDTH]} + {1'b0, addend};
    prod_next = {sum, acc[DATA_WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      mcand <= '0;
    end else if (load) begin
      acc   <= {{DATA_WIDTH{1'b0}}, op_b};
      mcand <= op_a;
    end else if (flush) begin
      acc   <= '0;
    end else if (step) begin
      acc   <= prod_next;
    end
  end

endmodule

// File: rtl/mult_sequencer.sv
// Multi-cycle unsigned multiply for the EX stage: stalls the front end while the
// shift-add runs, then hands the low word to writeback and latches the high word in HI.
module mult_sequencer
  import mult_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int REG_ADDR_LEN = REG_ADDR_LEN_DEF,
  parameter int CNT_WIDTH    = CNT_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     flush,
  input  logic [DATA_WIDTH-1:0]    op_a,
  input  logic [DATA_WIDTH-1:0]    op_b,
  input  logic [REG_ADDR_LEN-1:0]  dest_in,
  output logic                     stall,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [REG_ADDR_LEN-1:0]  wb_dest,
  output logic [DATA_WIDTH-1:0]    wb_data,
  output logic [DATA_WIDTH-1:0]    hi_data
);

  ms_state_e               state;
  logic [CNT_WIDTH-1:0]    cnt;
  logic [REG_ADDR_LEN-1:0] dest_q;
  logic [2*DATA_WIDTH-1:0] prod_next;
  logic                    load;
  logic                    step;
  logic                    dp_flush;
  logic                    last_iter;

  // A new op is accepted from IDLE, or straight out of DONE when the result retires
  always_comb begin
    load      = start && !flush &&
                (state == MS_IDLE || (state == MS_DONE && wb_ready));
    step      = (state == MS_RUN) && !flush;
    dp_flush  = (state == MS_RUN) && flush;
    last_iter = (cnt == CNT_WIDTH'(DATA_WIDTH - 1));
    stall     = (state == MS_RUN) ||
                (state == MS_DONE && !wb_ready) ||
                (state == MS_IDLE && start && !flush);
  end

  mult_datapath #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_datapath (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .step      (step),
    .flush     (dp_flush),
    .op_a      (op_a),
    .op_b      (op_b),
    .prod_next (prod_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= MS_IDLE;
      cnt      <= '0;
      dest_q   <= '0;
      wb_valid <= 1'b0;
      wb_dest  <= '0;
      wb_data  <= '0;
      hi_data  <= '0;
    end else begin
      case (state)
        MS_IDLE: begin
          if (load) begin
            dest_q <= dest_in;
            cnt    <= '0;
            state  <= MS_RUN;
          end
        end
        MS_RUN: begin
          if (flush) begin
            cnt   <= '0;
            state <= MS_IDLE;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
            // Final iteration: the product is committed here, HI included
            if (last_iter) begin
              wb_valid <= 1'b1;
              wb_dest  <= dest_q;
              wb_data  <= prod_next[DATA_WIDTH-1:0];
              hi_data  <= prod_next[2*DATA_WIDTH-1:DATA_WIDTH];
              state    <= MS_DONE;
            end
          end
        end
        MS_DONE: begin
          if (wb_ready) begin
            wb_valid <= 1'b0;
            if (load) begin
              dest_q <= dest_in;
              cnt    <= '0;
              state  <= MS_RUN;
            end else begin
              state <= MS_IDLE;
            end
          end
        end
        default: begin
          state <= MS_IDLE;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // The EX stage must not present a new multiply while this one is still busy
  start_while_busy_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(start && (state == MS_RUN || (state == MS_DONE && !wb_ready))));
`endif

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer: product table plus hand sequences for
// backpressure, flush, back-to-back issue and asynchronous reset.
module tb_mult_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [3:0]  dest_in;
  logic        stall;
  logic        wb_valid;
  logic        wb_ready;
  logic [3:0]  wb_dest;
  logic [15:0] wb_data;
  logic [15:0] hi_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  d;
    logic [15:0] lo;
    logic [15:0] hi;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  mult_sequencer #(
    .DATA_WIDTH   (16),
    .REG_ADDR_LEN (4),
    .CNT_WIDTH    (5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .flush    (flush),
    .op_a     (op_a),
    .op_b     (op_b),
    .dest_in  (dest_in),
    .stall    (stall),
    .wb_valid (wb_valid),
    .wb_ready (wb_ready),
    .wb_dest  (wb_dest),
    .wb_data  (wb_data),
    .hi_data  (hi_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one multiply with wb_ready=1 and check latency, result and one-cycle pulse
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] d,
                        input logic [15:0] exp_lo, input logic [15:0] exp_hi, input string name);
    int n;
    logic stall_drop;
    start = 1'b1; op_a = a; op_b = b; dest_in = d; wb_ready = 1'b1; flush = 1'b0;
    #1 check({name, " stall_at_start"}, stall, 1);
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    stall_drop = 1'b0;
    while (!wb_valid && n < 40) begin
      if (!stall) stall_drop = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    check({name, " latency"}, n, 16);
    check({name, " stall_run"}, stall_drop, 0);
    check({name, " wb_data"}, wb_data, exp_lo);
    check({name, " hi_data"}, hi_data, exp_hi);
    check({name, " wb_dest"}, wb_dest, d);
    check({name, " stall_done_ready"}, stall, 0);
    @(posedge clk); #1;
    check({name, " valid_pulse_end"}, wb_valid, 0);
  endtask

  initial begin
    int n;
    logic seen;

    vecs[0] = '{a: 16'd3,      b: 16'd5,      d: 4'd4,  lo: 16'd15,     hi: 16'h0000};
    vecs[1] = '{a: 16'hFFFF,   b: 16'hFFFF,   d: 4'd1,  lo: 16'h0001,   hi: 16'hFFFE};
    vecs[2] = '{a: 16'd0,      b: 16'h1234,   d: 4'd2,  lo: 16'h0000,   hi: 16'h0000};
    vecs[3] = '{a: 16'h8000,   b: 16'd2,      d: 4'd15, lo: 16'h0000,   hi: 16'h0001};
    vecs[4] = '{a: 16'hABCD,   b: 16'h1234,   d: 4'd7,  lo: 16'h4FA4,   hi: 16'h0C37};
    vecs[5] = '{a: 16'd255,    b: 16'd255,    d: 4'd3,  lo: 16'hFE01,   hi: 16'h0000};

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op_a = '0; op_b = '0;
    dest_in = '0; wb_ready = 1'b0;
    #2;
    check("reset wb_valid", wb_valid, 0);
    check("reset stall", stall, 0);
    check("reset wb_dest", wb_dest, 0);
    check("reset wb_data", wb_data, 0);
    check("reset hi_data", hi_data, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].lo, vecs[i].hi, $sformatf("vec%0d", i));

    // start together with flush in IDLE is ignored
    start = 1'b1; flush = 1'b1; op_a = 16'd9; op_b = 16'd9;
    #1 check("start_flush stall", stall, 0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("start_flush still_idle", stall, 0);
    check("start_flush no_valid", wb_valid, 0);

    // Backpressure: 7*9 held in DONE for five cycles
    start = 1'b1; op_a = 16'd7; op_b = 16'd9; dest_in = 4'd5; wb_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!wb_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp latency", n, 16);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp hold%0d valid", i), wb_valid, 1);
      check($sformatf("bp hold%0d data", i), wb_data, 63);
      check($sformatf("bp hold%0d stall", i), stall, 1);
      @(posedge clk); #1;
    end
    check("bp dest", wb_dest, 5);
    wb_ready = 1'b1;
    #1 check("bp release stall", stall, 0);
    @(posedge clk); #1;
    check("bp released valid", wb_valid, 0);

    // Flush mid-run: load HI with a known nonzero value first
    run_op(16'hFFFF, 16'hFFFF, 4'd6, 16'h0001, 16'hFFFE, "pre_flush");
    start = 1'b1; op_a = 16'd300; op_b = 16'd200; dest_in = 4'd8;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    #1 check("flush stall_before", stall, 1);
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush stall_after", stall, 0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (wb_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("flush no_valid", seen, 0);
    check("flush hi_kept", hi_data, 16'hFFFE);
    check("flush idle_stall", stall, 0);

    // Back-to-back: retire 11*13 and issue 2*2 in the same DONE cycle
    start = 1'b1; op_a = 16'd11; op_b = 16'd13; dest_in = 4'd10; wb_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!wb_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b first latency", n, 16);
    check("b2b first data", wb_data, 143);
    check("b2b first dest", wb_dest, 10);
    start = 1'b1; op_a = 16'd2; op_b = 16'd2; dest_in = 4'd9;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b accepted valid_low", wb_valid, 0);
    check("b2b running stall", stall, 1);
    n = 0;
    while (!wb_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b second latency", n, 16);
    check("b2b second data", wb_data, 4);
    check("b2b second dest", wb_dest, 9);
    check("b2b second hi", hi_data, 0);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a run
    start = 1'b1; op_a = 16'd123; op_b = 16'd45; dest_in = 4'd12;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst wb_valid", wb_valid, 0);
    check("arst stall", stall, 0);
    check("arst wb_dest", wb_dest, 0);
    check("arst wb_data", wb_data, 0);
    check("arst hi_data", hi_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst idle_after", stall, 0);
    run_op(16'd6, 16'd7, 4'd11, 16'd42, 16'd0, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
